// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: registered N-way priority encoder with fixed or round-robin priority and a valid/ready output
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_in     level-sensitive request vector, bit i = channel i
//   mode       0 = fixed priority (bit 0 highest), 1 = round-robin starting at ptr
//   out_ready  consumer accepts the current winner
//   out_valid  code_out/grant_out hold a valid winner
//   code_out   binary index of the winner (holds its last value when idle)
//   grant_out  one-hot winner, zero when out_valid=0
//   grant_cnt  saturating handshake counter, present only with RR_PRIORITY_ENCODER_GRANT_CNT_EN
module rr_priority_encoder #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic             mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] code_out,
  output logic [N-1:0]     grant_out
`ifdef RR_PRIORITY_ENCODER_GRANT_CNT_EN
  ,
  output logic [15:0]      grant_cnt
`endif
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [IDX_W-1:0] ptr, next_ptr, base, win;
  logic [IDX_W:0] sum;
  logic [2*N-1:0] dbl;
  logic found, handshake;
  always_comb begin
    handshake = (state == HOLD) && out_ready;
    next_ptr = (handshake && mode) ? ((code_out == IDX_W'(N - 1)) ? '0 : code_out + 1'b1) : ptr;
    base = mode ? next_ptr : '0;
    // rotate so the scan start lands at bit 0; the lowest set bit of the rotated vector wins
    dbl = {req_in, req_in} >> base;
    found = |req_in;
    win = '0;
    sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        sum = {1'b0, base} + (IDX_W + 1)'(k);
        win = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N)) : sum[IDX_W-1:0];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      code_out <= '0;
      grant_out <= '0;
      ptr <= '0;
    end else if (state == IDLE || out_ready) begin
      ptr <= next_ptr;
      out_valid <= found;
      grant_out <= found ? N'(1) << win : '0;
      code_out <= found ? win : code_out;
      state <= found ? HOLD : IDLE;
    end
  end
`ifdef RR_PRIORITY_ENCODER_GRANT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) grant_cnt <= '0;
    else if (out_valid && out_ready && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_rr_priority_encoder.sv
// tb_rr_priority_encoder: directed table, N=5 wrap sequence and randomized model comparison for rr_priority_encoder
module tb_rr_priority_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, mode, out_ready;
  logic [7:0] req;
  logic [4:0] req5;
  logic v8, v5;
  logic [2:0] c8, c5;
  logic [7:0] g8;
  logic [4:0] g5;
`ifdef RR_PRIORITY_ENCODER_GRANT_CNT_EN
  logic [15:0] cnt8, cnt5;
`endif
  int checks = 0, errors = 0;
  bit m_valid = 0;
  int m_code = 0, m_ptr = 0, m_cnt = 0;

  rr_priority_encoder #(.N(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req), .mode(mode), .out_ready(out_ready),
    .out_valid(v8), .code_out(c8), .grant_out(g8)
`ifdef RR_PRIORITY_ENCODER_GRANT_CNT_EN
    , .grant_cnt(cnt8)
`endif
  );
  rr_priority_encoder #(.N(5), .IDX_W(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .req_in(req5), .mode(mode), .out_ready(out_ready),
    .out_valid(v5), .code_out(c5), .grant_out(g5)
`ifdef RR_PRIORITY_ENCODER_GRANT_CNT_EN
    , .grant_cnt(cnt5)
`endif
  );

  typedef struct {
    logic rst_n; logic [7:0] req; logic mode; logic rdy;
    logic v; logic [2:0] c; logic [7:0] g;
  } vec_t;
  vec_t tbl[27];

  function automatic vec_t mk(logic r, logic [7:0] q, logic md, logic rd, logic v, logic [2:0] c, logic [7:0] g);
    vec_t t;
    t.rst_n = r; t.req = q; t.mode = md; t.rdy = rd; t.v = v; t.c = c; t.g = g;
    return t;
  endfunction

  // winner from the set of requested channels: fixed picks the smallest,
  // round-robin picks the smallest index >= p, else wraps to the smallest
  function automatic int ref_win(logic [7:0] r, logic md, int p);
    int idx[$];
    int w;
    for (int i = 0; i < 8; i++) if (r[i]) idx.push_back(i);
    if (idx.size() == 0) return -1;
    w = idx[0];
    if (md) begin
      for (int j = idx.size() - 1; j >= 0; j--) if (idx[j] >= p) w = idx[j];
    end
    return w;
  endfunction

  task automatic model_step();
    int w;
    if (!rst_n) begin
      m_valid = 0; m_code = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_valid || out_ready) begin
      if (m_valid) begin
        if (m_cnt < 65535) m_cnt++;
        if (mode) m_ptr = (m_code + 1) % 8;
      end
      w = ref_win(req, mode, m_ptr);
      if (w >= 0) begin m_valid = 1; m_code = w; end
      else m_valid = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(string name);
    chk({name, ".valid"}, 64'(v8), 64'(m_valid));
    chk({name, ".code"}, 64'(c8), 64'(m_code));
    chk({name, ".grant"}, 64'(g8), m_valid ? 64'(1) << m_code : 64'd0);
`ifdef RR_PRIORITY_ENCODER_GRANT_CNT_EN
    chk({name, ".cnt"}, 64'(cnt8), 64'(m_cnt));
`endif
  endtask

  initial begin
    int exp5[4];
    rst_n = 0; mode = 0; out_ready = 0; req = '0; req5 = '0;
    tbl[0]  = mk(0, 8'hFF, 0, 1, 0, 0, 8'h00);
    tbl[1]  = mk(0, 8'hFF, 0, 1, 0, 0, 8'h00);
    tbl[2]  = mk(1, 8'hFF, 0, 1, 1, 0, 8'h01);
    tbl[3]  = mk(1, 8'hA4, 0, 1, 1, 2, 8'h04);
    tbl[4]  = mk(1, 8'hA4, 0, 1, 1, 2, 8'h04);
    tbl[5]  = mk(1, 8'hA4, 0, 1, 1, 2, 8'h04);
    tbl[6]  = mk(0, 8'h85, 1, 1, 0, 0, 8'h00);
    tbl[7]  = mk(1, 8'h85, 1, 1, 1, 0, 8'h01);
    tbl[8]  = mk(1, 8'h85, 1, 1, 1, 2, 8'h04);
    tbl[9]  = mk(1, 8'h85, 1, 1, 1, 7, 8'h80);
    tbl[10] = mk(1, 8'h85, 1, 1, 1, 0, 8'h01);
    tbl[11] = mk(1, 8'h85, 1, 1, 1, 2, 8'h04);
    tbl[12] = mk(1, 8'h85, 1, 1, 1, 7, 8'h80);
    tbl[13] = mk(1, 8'h10, 1, 1, 1, 4, 8'h10);
    tbl[14] = mk(1, 8'h10, 1, 0, 1, 4, 8'h10);
    tbl[15] = mk(1, 8'h10, 1, 0, 1, 4, 8'h10);
    tbl[16] = mk(1, 8'h10, 1, 0, 1, 4, 8'h10);
    tbl[17] = mk(1, 8'h10, 1, 0, 1, 4, 8'h10);
    tbl[18] = mk(1, 8'h00, 1, 0, 1, 4, 8'h10);
    tbl[19] = mk(1, 8'h00, 1, 1, 0, 4, 8'h00);
    tbl[20] = mk(1, 8'h00, 1, 1, 0, 4, 8'h00);
    tbl[21] = mk(1, 8'h02, 1, 0, 1, 1, 8'h02);
    tbl[22] = mk(1, 8'h03, 0, 0, 1, 1, 8'h02);
    tbl[23] = mk(1, 8'h03, 0, 1, 1, 0, 8'h01);
    tbl[24] = mk(1, 8'h03, 1, 1, 1, 1, 8'h02);
    tbl[25] = mk(0, 8'h03, 1, 1, 0, 0, 8'h00);
    tbl[26] = mk(1, 8'h00, 1, 1, 0, 0, 8'h00);
    @(posedge clk);
    #1;
    for (int i = 0; i < 27; i++) begin
      rst_n = tbl[i].rst_n; req = tbl[i].req; mode = tbl[i].mode; out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d.valid", i), 64'(v8), 64'(tbl[i].v));
      chk($sformatf("tbl%0d.code", i), 64'(c8), 64'(tbl[i].c));
      chk($sformatf("tbl%0d.grant", i), 64'(g8), 64'(tbl[i].g));
    end
    // N=5 round-robin must wrap the pointer mod 5
    rst_n = 0; req = '0; req5 = '0;
    tick();
    rst_n = 1; mode = 1; out_ready = 1;
    req5 = 5'b10001;
    exp5 = '{0, 4, 0, 4};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("n5a%0d.code", i), 64'(c5), 64'(exp5[i]));
      chk($sformatf("n5a%0d.valid", i), 64'(v5), 64'd1);
    end
    req5 = 5'b10010;
    exp5 = '{1, 4, 1, 4};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("n5b%0d.code", i), 64'(c5), 64'(exp5[i]));
      chk($sformatf("n5b%0d.grant", i), 64'(g5), 64'(1) << exp5[i]);
    end
    req5 = '0;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      req = ($urandom_range(0, 3) == 0) ? 8'h00 :
            ($urandom_range(0, 1) != 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      mode = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      chk_model($sformatf("rnd%0d", i));
    end
`ifdef RR_PRIORITY_ENCODER_GRANT_CNT_EN
    rst_n = 0; out_ready = 1; mode = 0; req = 8'h01;
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("cnt.three", 64'(cnt8), 64'd3);
    rst_n = 0;
    tick();
    chk("cnt.reset", 64'(cnt8), 64'd0);
    rst_n = 1;
    tick();
    tick();
    chk("cnt.one", 64'(cnt8), 64'd1);
    for (int i = 0; i < 65540; i++) tick();
    chk("cnt.sat", 64'(cnt8), 64'hFFFF);
    chk_model("cnt.model");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
